result_stage_pipe: RTL and testbench

//  Parametrised in-flight result staging pipe for the SPU execution back end.

---
 rtl/result_stage_pipe.sv | 129 ++++++++++++
 tb/tb_result_stage_pipe.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_stage_pipe.sv
// In-flight result staging pipe: CH issue channels x DEPTH stages, write-back at the last stage.
// Define RESULT_PIPE_FWD_EN to build the operand forwarding network; otherwise rd_hit/rd_data are 0.
module result_stage_pipe #(
  parameter int unsigned CH    = 2,
  parameter int unsigned DEPTH = 7,
  parameter int unsigned W     = 128,
  parameter int unsigned AW    = 7,
  parameter int unsigned NRD   = 6,
  parameter int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CH-1:0]     in_valid,
  input  logic [CH*AW-1:0]  in_rt_addr,
  input  logic [CH*W-1:0]   in_result,
  input  logic [CH*LW-1:0]  in_lat,
  input  logic              flush,
  input  logic [LW-1:0]     flush_stage,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_hit,
  output logic [NRD*W-1:0]  rd_data,
  output logic [CH-1:0]     wb_valid,
  output logic [CH*AW-1:0]  wb_rt_addr,
  output logic [CH*W-1:0]   wb_data
);

  logic [CH-1:0] valid_q [DEPTH];
  logic [AW-1:0] addr_q  [DEPTH][CH];
  logic [W-1:0]  data_q  [DEPTH][CH];
  logic [LW-1:0] lat_q   [DEPTH][CH];
  logic [LW-1:0] lat_clamped [CH];

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      lat_clamped[c] = in_lat[c*LW +: LW];
      if (lat_clamped[c] == '0) begin
        lat_clamped[c] = LW'(1);
      end else if (32'(lat_clamped[c]) > DEPTH) begin
        lat_clamped[c] = LW'(DEPTH);
      end
    end
  end

  // Only the valid bits are reset; a flush kills stages below flush_stage and the incoming issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        valid_q[s] <= '0;
      end
    end else begin
      valid_q[0] <= flush ? '0 : in_valid;
      for (int s = 1; s < DEPTH; s++) begin
        if (flush && ((s - 1) < int'(flush_stage))) begin
          valid_q[s] <= '0;
        end else begin
          valid_q[s] <= valid_q[s-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      addr_q[0][c] <= in_rt_addr[c*AW +: AW];
      data_q[0][c] <= in_result[c*W +: W];
      lat_q[0][c]  <= lat_clamped[c];
    end
    for (int s = 1; s < DEPTH; s++) begin
      for (int c = 0; c < CH; c++) begin
        addr_q[s][c] <= addr_q[s-1][c];
        data_q[s][c] <= data_q[s-1][c];
        lat_q[s][c]  <= lat_q[s-1][c];
      end
    end
  end

  // Payload is gated by valid so reset and idle slots present zeros.
  always_comb begin
    wb_valid   = '0;
    wb_rt_addr = '0;
    wb_data    = '0;
    for (int c = 0; c < CH; c++) begin
      wb_valid[c] = valid_q[DEPTH-1][c];
      if (valid_q[DEPTH-1][c]) begin
        wb_rt_addr[c*AW +: AW] = addr_q[DEPTH-1][c];
        wb_data[c*W +: W]      = data_q[DEPTH-1][c];
      end
    end
  end

`ifdef RESULT_PIPE_FWD_EN
  logic [NRD-1:0] fwd_found;

  // Youngest stage first, higher channel first; the first match decides, ready or not.
  always_comb begin
    rd_hit    = '0;
    rd_data   = '0;
    fwd_found = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int s = 0; s < DEPTH; s++) begin
        for (int c = CH - 1; c >= 0; c--) begin
          if (!fwd_found[p] && valid_q[s][c] && (addr_q[s][c] == rd_addr[p*AW +: AW])) begin
            fwd_found[p] = 1'b1;
            if (int'(lat_q[s][c]) <= s + 1) begin
              rd_hit[p]          = 1'b1;
              rd_data[p*W +: W]  = data_q[s][c];
            end
          end
        end
      end
    end
  end
`else
  logic unused_fwd;

  assign rd_hit  = '0;
  assign rd_data = '0;

  always_comb begin
    unused_fwd = ^rd_addr;
    for (int s = 0; s < DEPTH; s++) begin
      for (int c = 0; c < CH; c++) begin
        unused_fwd = unused_fwd ^ (^lat_q[s][c]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_result_stage_pipe.sv
// Self-checking bench for result_stage_pipe: directed scenarios plus randomized traffic
// checked against an in-flight instruction list model.
module tb_result_stage_pipe;
  localparam int CH = 2, DEPTH = 7, W = 128, AW = 7, NRD = 6, LW = 3;
`ifdef RESULT_PIPE_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [CH-1:0]     in_valid;
  logic [CH*AW-1:0]  in_rt_addr;
  logic [CH*W-1:0]   in_result;
  logic [CH*LW-1:0]  in_lat;
  logic              flush;
  logic [LW-1:0]     flush_stage;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD-1:0]    rd_hit;
  logic [NRD*W-1:0]  rd_data;
  logic [CH-1:0]     wb_valid;
  logic [CH*AW-1:0]  wb_rt_addr;
  logic [CH*W-1:0]   wb_data;

  int n_tests = 0;
  int n_fail  = 0;

  result_stage_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_rt_addr (in_rt_addr),
    .in_result  (in_result),
    .in_lat     (in_lat),
    .flush      (flush),
    .flush_stage(flush_stage),
    .rd_addr    (rd_addr),
    .rd_hit     (rd_hit),
    .rd_data    (rd_data),
    .wb_valid   (wb_valid),
    .wb_rt_addr (wb_rt_addr),
    .wb_data    (wb_data)
  );

  always #5 clk = ~clk;

  // Reference: a list of in-flight instructions, each aged by one per clock.
  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    int            lat;
    int            age;
    int            ch;
  } ent_t;
  ent_t model_q[$];
  ent_t nxt_q[$];
  ent_t tmp_e;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      model_q.delete();
    end else begin
      nxt_q.delete();
      foreach (model_q[i]) begin
        tmp_e = model_q[i];
        if (!(flush && tmp_e.age < int'(flush_stage)) && tmp_e.age + 1 < DEPTH) begin
          tmp_e.age = tmp_e.age + 1;
          nxt_q.push_back(tmp_e);
        end
      end
      if (!flush) begin
        for (int c = 0; c < CH; c++) begin
          if (in_valid[c]) begin
            tmp_e.addr = in_rt_addr[c*AW +: AW];
            tmp_e.data = in_result[c*W +: W];
            tmp_e.lat  = int'(in_lat[c*LW +: LW]);
            if (tmp_e.lat < 1) tmp_e.lat = 1;
            if (tmp_e.lat > DEPTH) tmp_e.lat = DEPTH;
            tmp_e.age  = 0;
            tmp_e.ch   = c;
            nxt_q.push_back(tmp_e);
          end
        end
      end
      model_q = nxt_q;
    end
  end

  function automatic void exp_wb(input int c, output bit v, output logic [AW-1:0] a,
                                 output logic [W-1:0] d);
    v = 1'b0; a = '0; d = '0;
    foreach (model_q[i]) begin
      if (model_q[i].age == DEPTH - 1 && model_q[i].ch == c) begin
        v = 1'b1; a = model_q[i].addr; d = model_q[i].data;
      end
    end
  endfunction

  function automatic void exp_fwd(input logic [AW-1:0] a, output bit found, output bit hit,
                                  output logic [W-1:0] d);
    int best_age = DEPTH;
    int best_ch  = -1;
    found = 1'b0; hit = 1'b0; d = '0;
    foreach (model_q[i]) begin
      if (model_q[i].addr == a && (model_q[i].age < best_age ||
          (model_q[i].age == best_age && model_q[i].ch > best_ch))) begin
        best_age = model_q[i].age;
        best_ch  = model_q[i].ch;
        found    = 1'b1;
        hit      = FwdEn && (model_q[i].lat <= model_q[i].age + 1);
        d        = hit ? model_q[i].data : '0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid    = '0;
    flush       = 1'b0;
    flush_stage = '0;
    in_lat      = '0;
  endtask

  task automatic drain();
    idle_inputs();
    flush       = 1'b1;
    flush_stage = 3'd7;
    tick();
    idle_inputs();
  endtask

  task automatic issue(input int c, input logic [AW-1:0] a, input logic [W-1:0] d, input int l);
    in_valid[c]            = 1'b1;
    in_rt_addr[c*AW +: AW] = a;
    in_result[c*W +: W]    = d;
    in_lat[c*LW +: LW]     = LW'(l);
  endtask

  task automatic set_rd(input logic [AW-1:0] a);
    rd_addr = {NRD{a}};
  endtask

  task automatic test_reset();
    idle_inputs();
    in_rt_addr = '0;
    in_result  = '0;
    set_rd(7'd1);
    #3;
    n_tests++;
    if (wb_valid !== '0 || rd_hit !== '0 || wb_data !== '0 || wb_rt_addr !== '0
        || rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: wb_valid=%b rd_hit=%b wb_addr=%h want all zero",
               wb_valid, rd_hit, wb_rt_addr);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] d1 = {8{16'h1F0F}};
    drain();
    issue(0, 7'd1, d1, 2);
    set_rd(7'd1);
    for (int k = 0; k <= 8; k++) begin
      tick();
      idle_inputs();
      if (k == 0) begin
        n_tests++;
        if (rd_hit !== '0) begin
          n_fail++; $display("FAIL basic_hit_e0: got %b want 0", rd_hit);
        end
      end
      if (k == 1) begin
        n_tests++;
        if (rd_hit !== {NRD{FwdEn}} || rd_data[W-1:0] !== (FwdEn ? d1 : '0)) begin
          n_fail++;
          $display("FAIL basic_hit_e1: got hit=%b data=%h want hit=%b", rd_hit,
                   rd_data[W-1:0], {NRD{FwdEn}});
        end
      end
      n_tests++;
      if (wb_valid[0] !== (k == 6) || (k == 6 && (wb_rt_addr[AW-1:0] !== 7'd1
          || wb_data[W-1:0] !== d1))) begin
        n_fail++;
        $display("FAIL basic_wb_e%0d: got v=%b addr=%0d want v=%b addr=1", k, wb_valid[0],
                 wb_rt_addr[AW-1:0], (k == 6));
      end
    end
  endtask

  task automatic test_youngest();
    logic [W-1:0] da = {16{8'hAA}};
    logic [W-1:0] db = {16{8'hBB}};
    drain();
    issue(0, 7'd3, da, 2);
    tick();
    idle_inputs();
    issue(0, 7'd3, db, 2);
    tick();
    idle_inputs();
    set_rd(7'd3);
    #1;
    n_tests++;
    if (rd_hit !== '0) begin
      n_fail++; $display("FAIL youngest_stall: got %b want 0", rd_hit);
    end
    tick();
    n_tests++;
    if (rd_hit !== {NRD{FwdEn}} || rd_data[W-1:0] !== (FwdEn ? db : '0)) begin
      n_fail++;
      $display("FAIL youngest_hit: got hit=%b data=%h", rd_hit, rd_data[W-1:0]);
    end
  endtask

  task automatic test_same_stage();
    logic [W-1:0] d0 = {16{8'h11}};
    logic [W-1:0] d1 = {16{8'h22}};
    drain();
    issue(0, 7'd5, d0, 1);
    issue(1, 7'd5, d1, 1);
    set_rd(7'd5);
    for (int k = 0; k <= 7; k++) begin
      tick();
      idle_inputs();
      if (k == 0) begin
        n_tests++;
        if (rd_hit !== {NRD{FwdEn}} || rd_data[W-1:0] !== (FwdEn ? d1 : '0)) begin
          n_fail++;
          $display("FAIL same_stage_fwd: got hit=%b data=%h", rd_hit, rd_data[W-1:0]);
        end
      end
      n_tests++;
      if (wb_valid !== ((k == 6) ? 2'b11 : 2'b00)) begin
        n_fail++;
        $display("FAIL same_stage_wb_e%0d: got %b want %b", k, wb_valid,
                 (k == 6) ? 2'b11 : 2'b00);
      end
    end
  endtask

  task automatic test_flush();
    bit [127:0] seen = '0;
    bit [127:0] want = '0;
    want[10] = 1'b1;
    want[11] = 1'b1;
    drain();
    for (int i = 0; i < 5; i++) begin
      issue(0, AW'(10 + i), W'(i + 1), 3);
      tick();
      idle_inputs();
    end
    issue(0, 7'd15, W'(99), 1);
    flush       = 1'b1;
    flush_stage = 3'd3;
    tick();
    idle_inputs();
    set_rd(7'd12);
    #1;
    n_tests++;
    if (rd_hit !== '0) begin
      n_fail++; $display("FAIL flush_killed_fwd: got %b want 0", rd_hit);
    end
    set_rd(7'd11);
    #1;
    n_tests++;
    if (rd_hit !== {NRD{FwdEn}}) begin
      n_fail++; $display("FAIL flush_survivor_fwd: got %b want %b", rd_hit, {NRD{FwdEn}});
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      for (int c = 0; c < CH; c++) begin
        if (wb_valid[c]) seen[wb_rt_addr[c*AW +: AW]] = 1'b1;
      end
    end
    n_tests++;
    if (seen !== want) begin
      n_fail++; $display("FAIL flush_wb_set: got %h want %h", seen, want);
    end
  endtask

  task automatic test_reset_mid();
    drain();
    for (int i = 0; i < DEPTH; i++) begin
      issue(0, AW'(20 + i), {$urandom(), $urandom(), $urandom(), $urandom()}, 1);
      issue(1, AW'(40 + i), {$urandom(), $urandom(), $urandom(), $urandom()}, 1);
      tick();
      idle_inputs();
    end
    set_rd(AW'(20 + DEPTH - 1));
    #1;
    n_tests++;
    if (wb_valid !== 2'b11 || rd_hit !== {NRD{FwdEn}}) begin
      n_fail++; $display("FAIL reset_mid_full: got wb=%b hit=%b", wb_valid, rd_hit);
    end
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (wb_valid !== '0 || rd_hit !== '0 || wb_data !== '0 || rd_data !== '0) begin
      n_fail++; $display("FAIL reset_mid_async: got wb=%b hit=%b want 0", wb_valid, rd_hit);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 2 * DEPTH; k++) begin
      tick();
      n_tests++;
      if (wb_valid !== '0) begin
        n_fail++; $display("FAIL reset_mid_stale_wb%0d: got %b want 0", k, wb_valid);
      end
    end
  endtask

  task automatic test_random();
    bit            ev, ef, eh;
    logic [AW-1:0] ea;
    logic [W-1:0]  ed;
    for (int n = 0; n < 400; n++) begin
      idle_inputs();
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 2) != 0) begin
          issue(c, AW'($urandom_range(0, 7)),
                {$urandom(), $urandom(), $urandom(), $urandom()}, int'($urandom_range(0, 7)));
        end
      end
      flush       = ($urandom_range(0, 9) == 0);
      flush_stage = LW'($urandom_range(0, 7));
      tick();
      idle_inputs();
      for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
      #1;
      for (int c = 0; c < CH; c++) begin
        exp_wb(c, ev, ea, ed);
        n_tests++;
        if (wb_valid[c] !== ev || (ev && (wb_rt_addr[c*AW +: AW] !== ea
            || wb_data[c*W +: W] !== ed))) begin
          n_fail++;
          $display("FAIL rand_wb c%0d cyc%0d: got v=%b addr=%0d want v=%b addr=%0d", c, n,
                   wb_valid[c], wb_rt_addr[c*AW +: AW], ev, ea);
        end
      end
      for (int p = 0; p < NRD; p++) begin
        exp_fwd(rd_addr[p*AW +: AW], ef, eh, ed);
        n_tests++;
        if (rd_hit[p] !== eh || (eh && rd_data[p*W +: W] !== ed)
            || (!ef && rd_data[p*W +: W] !== '0)) begin
          n_fail++;
          $display("FAIL rand_fwd p%0d cyc%0d: got hit=%b data=%h want hit=%b data=%h", p, n,
                   rd_hit[p], rd_data[p*W +: W], eh, ed);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_youngest();
    test_same_stage();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
